// File: rtl/booth3_mul_arbiter.sv
// rtl/booth3_mul_arbiter.sv - round-robin sharing of one external 8x8 signed multiplier between two requesters
// Optional feature: define MUL_ZERO_BYPASS_EN to answer zero-operand requests without a multiplier pass.
module booth3_mul_arbiter #(
  parameter int unsigned MUL_LAT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [15:0] rsp0_p,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [15:0] rsp1_p,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_p,
  output logic        busy
);

  localparam logic [2:0] LP_LAT = 3'(MUL_LAT);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_RESP} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last_grant;
  logic        r_owner;
  logic [2:0]  r_cnt;
  logic [7:0]  r_mul_a;
  logic [7:0]  r_mul_b;
  logic [15:0] r_result;

  logic        w_sel0;
  logic        w_sel1;
  logic        w_idle;
  logic        w_acc;
  logic        w_zero;
  logic        w_rsp_done;
  logic [7:0]  w_a;
  logic [7:0]  w_b;

  // On a tie the requester that was not granted last time wins.
  always_comb begin
    w_sel0     = req0_valid & (~req1_valid | r_last_grant);
    w_sel1     = req1_valid & (~req0_valid | ~r_last_grant);
    w_idle     = (r_state == S_IDLE);
    w_acc      = w_idle & (w_sel0 | w_sel1);
    w_a        = w_sel1 ? req1_a : req0_a;
    w_b        = w_sel1 ? req1_b : req0_b;
`ifdef MUL_ZERO_BYPASS_EN
    w_zero     = (w_a == 8'd0) | (w_b == 8'd0);
`else
    w_zero     = 1'b0;
`endif
    w_rsp_done = r_owner ? rsp1_ready : rsp0_ready;

    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_acc) w_state_nxt = w_zero ? S_RESP : S_CALC;
      S_CALC:  if (r_cnt == 3'd0) w_state_nxt = S_RESP;
      S_RESP:  if (w_rsp_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_cnt        <= 3'd0;
      r_mul_a      <= 8'd0;
      r_mul_b      <= 8'd0;
      r_result     <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_owner      <= w_sel1;
            r_last_grant <= w_sel1;
            if (w_zero) begin
              r_result <= 16'd0;
            end else begin
              r_mul_a <= w_a;
              r_mul_b <= w_b;
              r_cnt   <= LP_LAT;
            end
          end
        end
        S_CALC: begin
          if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
          else               r_result <= mul_p;
        end
        default: ;
      endcase
    end
  end

  assign req0_ready = w_idle & w_sel0;
  assign req1_ready = w_idle & w_sel1;
  assign rsp0_valid = (r_state == S_RESP) & ~r_owner;
  assign rsp1_valid = (r_state == S_RESP) & r_owner;
  assign rsp0_p     = rsp0_valid ? r_result : 16'd0;
  assign rsp1_p     = rsp1_valid ? r_result : 16'd0;
  assign mul_a      = r_mul_a;
  assign mul_b      = r_mul_b;
  assign busy       = ~w_idle;

endmodule

// File: tb/tb_booth3_mul_arbiter.sv
// tb/tb_booth3_mul_arbiter.sv - scoreboard bench for booth3_mul_arbiter with a pipelined multiplier model
module tb_booth3_mul_arbiter;

  localparam int LAT = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       rv = '0;
  logic [1:0]       rr = '0;
  logic [1:0][7:0]  ra = '0;
  logic [1:0][7:0]  rb = '0;
  logic [1:0]       rdy;
  logic [1:0]       sv;
  logic [1:0][15:0] sp;
  logic [7:0]       mul_a;
  logic [7:0]       mul_b;
  logic [15:0]      mul_p;
  logic             busy;

  int total = 0;
  int bad = 0;

  booth3_mul_arbiter #(.MUL_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(rv[0]), .req0_ready(rdy[0]), .req0_a(ra[0]), .req0_b(rb[0]),
    .rsp0_valid(sv[0]), .rsp0_ready(rr[0]), .rsp0_p(sp[0]),
    .req1_valid(rv[1]), .req1_ready(rdy[1]), .req1_a(ra[1]), .req1_b(rb[1]),
    .rsp1_valid(sv[1]), .rsp1_ready(rr[1]), .rsp1_p(sp[1]),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int x;
    x = $signed(a) * $signed(b);
    return x[15:0];
  endfunction

  function automatic int ref_lat(input logic [7:0] a, input logic [7:0] b);
`ifdef MUL_ZERO_BYPASS_EN
    if (a == 8'd0 || b == 8'd0) return 1;
`endif
    return 2 + LAT;
  endfunction

  // multiplier core: product appears LAT cycles after its operands
  logic [15:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= ref_mul(mul_a, mul_b);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_p = pipe[LAT-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  typedef struct packed {
    logic [15:0] p;
    logic [31:0] acc;
    logic [31:0] lat;
  } exp_t;

  exp_t        sb [2][$];
  int          outst = 0;
  logic        last = 1'b1;
  logic [1:0]  seen = '0;
  logic [1:0]  er;
  logic [31:0] cyc = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_hs", {rdy, sv, busy}, 0);
      chk("rst_p", sp, 0);
      chk("rst_mul", {mul_a, mul_b}, 0);
      sb[0].delete();
      sb[1].delete();
      outst = 0;
      last  = 1'b1;
      seen  = '0;
    end else begin
      cyc++;
      chk("busy", busy, outst != 0);
      er[0] = (outst == 0) && rv[0] && (!rv[1] || last);
      er[1] = (outst == 0) && rv[1] && (!rv[0] || !last);
      chk("ready", rdy, er);
      chk("rsp_excl", sv[0] & sv[1], 0);
      for (int n = 0; n < 2; n++) begin
        if (sv[n]) begin
          if (sb[n].size() == 0) begin
            timeout("spurious_rsp");
          end else begin
            chk("rsp_p", sp[n], sb[n][0].p);
            if (!seen[n]) begin
              chk("rsp_lat", cyc - sb[n][0].acc, sb[n][0].lat);
              seen[n] = 1'b1;
            end
            if (rr[n]) begin
              void'(sb[n].pop_front());
              seen[n] = 1'b0;
              outst--;
            end
          end
        end else begin
          chk("idle_p", sp[n], 0);
        end
      end
      for (int n = 0; n < 2; n++) begin
        if (er[n]) begin
          sb[n].push_back({ref_mul(ra[n], rb[n]), cyc, 32'(ref_lat(ra[n], rb[n]))});
          last = n[0];
          outst++;
        end
      end
    end
  end

  task automatic do_req(input int n, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input int hold);
    int t;
    rv[n] = 1'b1; ra[n] = a; rb[n] = b; rr[n] = (hold == 0);
    t = 0;
    do begin @(negedge clk); t++; end while (!(rv[n] && rdy[n]) && t < 50);
    if (t >= 50) timeout("dir_accept");
    @(posedge clk); #1 rv[n] = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!sv[n] && t < 50);
    if (t >= 50) timeout("dir_rsp");
    chk("dir_p", sp[n], exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_p", sp[n], exp);
      chk("hold_ready", rdy, 0);
    end
    if (hold > 0) begin
      @(posedge clk); #1 rr[n] = 1'b1;
      @(negedge clk);
      chk("hold_hs", sv[n], 1);
    end
  endtask

  task automatic drain();
    int t;
    rv = '0; rr = 2'b11;
    t = 0;
    while ((outst != 0 || busy) && t < 60) begin @(negedge clk); t++; end
    if (t >= 60) timeout("drain");
    @(posedge clk); #1;
  endtask

  logic [1:0] acc;
  logic [7:0] pre_a;
  int         t;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    do_req(0, 8'h03, 8'h05, 16'h000F, 0);
    drain();
    do_req(1, 8'h80, 8'h80, 16'h4000, 0);
    drain();
    do_req(1, 8'h7F, 8'h80, 16'hC080, 0);
    drain();

    // both requesters always valid: grants must alternate starting with 0
    rv = 2'b11; rr = 2'b11;
    ra[0] = 8'($urandom); rb[0] = 8'($urandom);
    ra[1] = 8'($urandom); rb[1] = 8'($urandom);
    for (int k = 0; k < 4; k++) begin
      t = 0;
      do begin @(negedge clk); t++; end while (rdy == 2'b00 && t < 50);
      if (t >= 50) timeout("alt_grant");
      chk("alt_grant", rdy, (k % 2 == 0) ? 2'b01 : 2'b10);
      acc = rdy;
      @(posedge clk); #1;
      for (int n = 0; n < 2; n++)
        if (acc[n]) begin ra[n] = 8'($urandom); rb[n] = 8'($urandom); end
    end
    drain();

    // response back-pressure while the other requester waits
    rv[1] = 1'b1; ra[1] = 8'hE7; rb[1] = 8'h19;
    do_req(0, 8'h12, 8'h34, 16'h03A8, 5);
    @(negedge clk);
    chk("next_ready1", rdy[1], 1);
    @(posedge clk); #1 rv[1] = 1'b0;
    drain();

    // reset in the middle of CALC drops the transaction
    rv[0] = 1'b1; ra[0] = 8'h55; rb[0] = 8'h66; rr = '0;
    t = 0;
    do begin @(negedge clk); t++; end while (!rdy[0] && t < 50);
    if (t >= 50) timeout("rst_accept");
    @(posedge clk); #1 rv[0] = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rr = 2'b11; rv = 2'b11;
    ra[0] = 8'h02; rb[0] = 8'h09; ra[1] = 8'h04; rb[1] = 8'hFD;
    @(negedge clk);
    chk("rst_tie", rdy, 2'b01);
    @(posedge clk); #1 rv[0] = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!rdy[1] && t < 50);
    if (t >= 50) timeout("rst_second");
    @(posedge clk); #1 rv[1] = 1'b0;
    drain();

    pre_a = mul_a;
    do_req(0, 8'h00, 8'h5A, 16'h0000, 0);
`ifdef MUL_ZERO_BYPASS_EN
    chk("bypass_mul_a", mul_a, pre_a);
`else
    chk("bypass_mul_a", mul_a, 8'h00);
`endif
    drain();

    for (int c = 0; c < 400; c++) begin
      @(negedge clk); acc = rv & rdy;
      @(posedge clk); #1;
      for (int n = 0; n < 2; n++) begin
        if (!rv[n] || acc[n]) begin
          rv[n] = ($urandom % 3) != 0;
          ra[n] = ($urandom % 5 == 0) ? 8'h00 : 8'($urandom);
          rb[n] = 8'($urandom);
        end
        rr[n] = ($urandom % 4) != 0;
      end
    end
    drain();
    chk("final_q0", sb[0].size(), 0);
    chk("final_q1", sb[1].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
